pump_softstart_driver: RTL
==========================

Name: pump_softstart_driver

Overview:
- Downstream of the top-level colour mixer: consumes the 3-bit motor enable vector (R, G, B pumps, bit 0 = R) and drives the pump power stages.
- Each channel gets a soft-start PWM ramp up to full-on.
- Only one channel may ramp at a time, to limit inrush current.
- A per-channel on-time watchdog latches a fault if a pump stays on too long.

Parameters:
- PWM_BITS, 8: width of the free-running PWM counter; PWM period = 2^PWM_BITS clk cycles.
- RAMP_STEP, 32: duty increment applied per ramp tick.
- RAMP_DIV, 2: number of PWM periods per ramp tick (must be >= 1).
- MAX_ON, 1048576: clk cycles a channel may spend in RAMP+ON before a fault is latched.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- motor_req  input  3  per-pump run request (level); bit0 = R, bit1 = G, bit2 = B.
- fault_clr  input  1  pulse; clears latched faults on channels whose request is low.
- pwm_out  output  3  registered pump drive.
- running  output  3  channel is in ON (full duty).
- fault_ch  output  3  per-channel latched watchdog fault.
- fault  output  1  OR of fault_ch.

Behaviour:
- Reset (reset=0, asynchronous):
  - All channels go to IDLE; duty, PWM counter, divider and watchdogs are cleared to 0.
  - pwm_out=0, running=0, fault_ch=0, fault=0.
  - Asserting reset mid-ramp or while in FAULT returns the channel to IDLE; faults are not retained.
- PWM counter:
  - cnt counts 0..2^PWM_BITS-1 every clk and wraps.
  - A wrap event occurs on the cycle cnt = max.
  - The divider counts wrap events 0..RAMP_DIV-1; tick = wrap event while the divider is at RAMP_DIV-1.
- Per-channel state machine (IDLE, WAIT, RAMP, ON, FAULT):
  - IDLE: req=1 -> WAIT next cycle.
  - WAIT: req=0 -> IDLE. Otherwise, when granted -> RAMP and duty loads RAMP_STEP.
  - Grant rule: no channel is in RAMP this cycle, and this is the lowest-index WAIT channel. At most one grant per cycle.
  - RAMP: on each tick, duty += RAMP_STEP, saturating at 2^PWM_BITS-1. When saturated -> ON in the same update.
  - ON: stays on while req=1.
  - req=0 in WAIT, RAMP or ON -> IDLE next cycle and duty is cleared. This is a hard stop, with no ramp-down.
  - Watchdog: counts every cycle in RAMP or ON. When the count reaches MAX_ON -> FAULT.
  - FAULT: output forced to 0. Exits to IDLE only on a cycle where fault_clr=1 and req=0; fault_clr is ignored while req=1.
- Outputs (all registered, 1-cycle latency from state/cnt):
  - pwm_out = 1 in ON; = (cnt < duty) in RAMP; = 0 otherwise.
  - running = 1 only in ON.
  - fault_ch = 1 only in FAULT; fault = OR of fault_ch.
- Simultaneous events:
  - req drop + tick: the drop wins.
  - req drop + watchdog expiry: the drop wins (IDLE, no fault).
  - Expiry + tick: FAULT wins.
  - The grant is released the same cycle the RAMP channel leaves RAMP; the next WAIT channel is granted on the following cycle.
- Latency: req rising at edge k -> WAIT at k+1 -> RAMP at k+2, if no other channel is ramping.
- Widths:
  - duty is PWM_BITS wide; the increment is computed one bit wider, then saturated.
  - The watchdog is $clog2(MAX_ON+1) bits and stops counting at MAX_ON.

Test Plan (PWM_BITS=4, RAMP_STEP=4, RAMP_DIV=1, MAX_ON=200 unless noted):
- Reset: drive reset=0 with arbitrary inputs -> all outputs 0. Release reset with motor_req=000 -> outputs stay 0 for 100 cycles.
- Single ramp: motor_req=001 -> RAMP 2 cycles later, duty 4. Then duty 8, 12, 15 at the next three ticks (16 cycles apart). pwm_out[0] high 4/16, then 8/16, then 12/16 of each period. running[0]=1 after duty reaches 15, and pwm_out[0] is then constant 1.
- Arbitration: motor_req 000->111 in one cycle -> R ramps first. G enters RAMP 1 cycle after R reaches ON, then B after G. Never more than one channel in RAMP.
- Hard stop: drop motor_req[1] mid-ramp, on the same cycle as a tick -> pwm_out[1]=0 next cycle and no duty increment. The waiting B is granted the cycle after.
- Watchdog: hold motor_req=001 -> fault_ch=001 and fault=1 after 200 cycles in RAMP+ON, pwm_out[0]=0. fault_clr with req=1 -> no change. req=0 then fault_clr -> fault cleared, channel returns to IDLE.
- Async reset mid-operation: assert reset while G is in ON and R is in FAULT -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pump_softstart_driver.sv
// Three-channel pump driver: soft-start PWM ramp to full-on, one channel ramping
// at a time, and a per-channel on-time watchdog that latches a fault.
module pump_softstart_driver #(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 32,
  parameter int RAMP_DIV  = 2,
  parameter int MAX_ON    = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] motor_req,
  input  logic       fault_clr,
  output logic [2:0] pwm_out,
  output logic [2:0] running,
  output logic [2:0] fault_ch,
  output logic       fault
);

  localparam int WD_W  = $clog2(MAX_ON + 1);
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS+1)'(RAMP_STEP);
  localparam logic [PWM_BITS-1:0] STEP_LOAD = PWM_BITS'(RAMP_STEP);
  localparam logic [WD_W-1:0]     WD_LIMIT  = WD_W'(MAX_ON);
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(RAMP_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_RAMP  = 3'd2,
    ST_ON    = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  state_e              state_r     [3];
  state_e              state_nxt_s [3];
  logic [PWM_BITS-1:0] duty_r      [3];
  logic [PWM_BITS-1:0] duty_nxt_s  [3];
  logic [WD_W-1:0]     wd_r        [3];
  logic [WD_W-1:0]     wd_nxt_s    [3];
  logic [WD_W-1:0]     wd_inc_s    [3];
  logic [PWM_BITS:0]   sum_s       [3];

  logic [PWM_BITS-1:0] cnt_r;
  logic [DIV_W-1:0]    div_r;
  logic                wrap_s;
  logic                tick_s;
  logic                ramp_busy_s;
  logic                taken_s;
  logic [2:0]          grant_s;
  logic [2:0]          pwm_nxt_s;
  logic [2:0]          run_nxt_s;
  logic [2:0]          flt_nxt_s;

  assign wrap_s = (cnt_r == DUTY_MAX);
  assign tick_s = wrap_s && (div_r == DIV_LAST);

  // Free-running PWM counter and ramp-tick divider
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {PWM_BITS{1'b0}};
      div_r <= {DIV_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + PWM_BITS'(1'b1);
      if (wrap_s) begin
        div_r <= (div_r == DIV_LAST) ? {DIV_W{1'b0}} : div_r + DIV_W'(1'b1);
      end
    end
  end

  // Ramp arbitration: lowest WAIT channel wins, only while nobody ramps
  always_comb begin
    ramp_busy_s = 1'b0;
    taken_s     = 1'b0;
    grant_s     = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (state_r[i] == ST_RAMP) begin
        ramp_busy_s = 1'b1;
      end else begin
        ramp_busy_s = ramp_busy_s;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (!ramp_busy_s && !taken_s && (state_r[i] == ST_WAIT)) begin
        grant_s[i] = 1'b1;
        taken_s    = 1'b1;
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  // Channel state, duty and watchdog registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        state_r[i] <= ST_IDLE;
        duty_r[i]  <= {PWM_BITS{1'b0}};
        wd_r[i]    <= {WD_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_r[i] <= state_nxt_s[i];
        duty_r[i]  <= duty_nxt_s[i];
        wd_r[i]    <= wd_nxt_s[i];
      end
    end
  end

  // Next-state logic; a request drop beats expiry, and expiry beats a tick
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_nxt_s[i] = state_r[i];
      duty_nxt_s[i]  = duty_r[i];
      wd_nxt_s[i]    = wd_r[i];
      wd_inc_s[i]    = wd_r[i] + WD_W'(1'b1);
      sum_s[i]       = {1'b0, duty_r[i]} + STEP_W;
      case (state_r[i])
        ST_IDLE: begin
          duty_nxt_s[i]  = {PWM_BITS{1'b0}};
          wd_nxt_s[i]    = {WD_W{1'b0}};
          state_nxt_s[i] = motor_req[i] ? ST_WAIT : ST_IDLE;
        end
        ST_WAIT: begin
          if (!motor_req[i]) begin
            state_nxt_s[i] = ST_IDLE;
          end else if (grant_s[i]) begin
            state_nxt_s[i] = ST_RAMP;
            duty_nxt_s[i]  = STEP_LOAD;
            wd_nxt_s[i]    = {WD_W{1'b0}};
          end else begin
            state_nxt_s[i] = ST_WAIT;
          end
        end
        ST_RAMP, ST_ON: begin
          if (!motor_req[i]) begin
            state_nxt_s[i] = ST_IDLE;
            duty_nxt_s[i]  = {PWM_BITS{1'b0}};
            wd_nxt_s[i]    = {WD_W{1'b0}};
          end else if (wd_inc_s[i] == WD_LIMIT) begin
            state_nxt_s[i] = ST_FAULT;
            duty_nxt_s[i]  = {PWM_BITS{1'b0}};
            wd_nxt_s[i]    = WD_LIMIT;
          end else begin
            wd_nxt_s[i] = wd_inc_s[i];
            if ((state_r[i] == ST_RAMP) && tick_s) begin
              if (sum_s[i] >= {1'b0, DUTY_MAX}) begin
                state_nxt_s[i] = ST_ON;
                duty_nxt_s[i]  = DUTY_MAX;
              end else begin
                duty_nxt_s[i] = sum_s[i][PWM_BITS-1:0];
              end
            end else begin
              state_nxt_s[i] = state_r[i];
            end
          end
        end
        ST_FAULT: begin
          if (fault_clr && !motor_req[i]) begin
            state_nxt_s[i] = ST_IDLE;
            wd_nxt_s[i]    = {WD_W{1'b0}};
          end else begin
            state_nxt_s[i] = ST_FAULT;
          end
        end
        default: begin
          state_nxt_s[i] = ST_IDLE;
          duty_nxt_s[i]  = {PWM_BITS{1'b0}};
          wd_nxt_s[i]    = {WD_W{1'b0}};
        end
      endcase
    end
  end

  // Output decode from current state and PWM counter
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      case (state_r[i])
        ST_ON:    pwm_nxt_s[i] = 1'b1;
        ST_RAMP:  pwm_nxt_s[i] = (cnt_r < duty_r[i]);
        default:  pwm_nxt_s[i] = 1'b0;
      endcase
      run_nxt_s[i] = (state_r[i] == ST_ON);
      flt_nxt_s[i] = (state_r[i] == ST_FAULT);
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_out  <= 3'b000;
      running  <= 3'b000;
      fault_ch <= 3'b000;
      fault    <= 1'b0;
    end else begin
      pwm_out  <= pwm_nxt_s;
      running  <= run_nxt_s;
      fault_ch <= flt_nxt_s;
      fault    <= |flt_nxt_s;
    end
  end

endmodule
